freq_counter_wb: RTL and testbench

//  Wishbone slave gated frequency counter; directly upstream of the control unit, which polls it over the bus.

---
 rtl/freq_counter_wb.sv | 175 +++++++++++++++++
 tb/tb_freq_counter_wb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_wb.sv
// Gated frequency counter with a Wishbone slave port.
// Synchronises sig_i, counts its rising edges over a window of GATE_CYCLES
// clocks and latches the total into RESULT for the control unit to poll.
//
// state | meaning
// IDLE  | waiting for an accepted START; RESULT/DONE/OVF hold
// ARM   | one cycle: clear edge count, load gate timer
// GATE  | sampling window; count rises, down-count the gate timer
// LATCH | one cycle: copy count into RESULT, raise DONE
module freq_counter_wb #(
   parameter logic [31:0] GATE_CYCLES = 32'd50_000_000,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] CTRL_ADDR   = 32'h8,
   parameter logic [31:0] RESULT_ADDR = 32'h9
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic        stb_i,
   input  logic        cyc_i,
   output logic        ack_o,
   input  logic        sig_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_GATE  = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sig_q, sig_d;
   logic                   sig_s, rise;
   logic [31:0]            count_q, count_d;
   logic [31:0]            timer_q, timer_d;
   logic [31:0]            result_q, result_d;
   logic                   done_q, done_d;
   logic                   ovf_q, ovf_d;
   logic                   hit_ctrl, hit_result;
   logic                   ctrl_wr, clr_req, start_req, start_ok;
   logic                   unused_ok;

   // Bus-side signals with no function in this block
   assign unused_ok = &{1'b0, cyc_i, sel_i[3:1], dat_i[31:8], dat_i[6:1]};

   // Address decode and CTRL write-strobe qualification; CLR beats START
   always_comb begin
      hit_ctrl   = stb_i && (addr_i == CTRL_ADDR);
      hit_result = stb_i && (addr_i == RESULT_ADDR);
      ctrl_wr    = hit_ctrl && we_i && sel_i[0];
      clr_req    = ctrl_wr && dat_i[0];
      start_req  = ctrl_wr && dat_i[7] && !dat_i[0];
      start_ok   = start_req && (state_q == ST_IDLE);
   end

   // Synchroniser shift and rising-edge detect on the synchronised signal
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
      sig_s  = sync_q[SYNC_STAGES-1];
      sig_d  = sig_s;
      rise   = sig_s & ~sig_q;
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; CLR aborts from any state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_ARM;
         ST_ARM:   state_d = ST_GATE;
         ST_GATE:  if (timer_q == 32'd0) state_d = ST_LATCH;
         ST_LATCH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (clr_req) begin
         state_d = ST_IDLE;
      end
   end

   // FSM outputs and combinational read mux
   always_comb begin
      busy_o = (state_q == ST_ARM) || (state_q == ST_GATE);
      ack_o  = hit_ctrl || hit_result;
      dat_o  = 32'd0;
      if (hit_ctrl) begin
         dat_o = {24'd0, 1'b0, done_q, busy_o, ovf_q, 4'd0};
      end else if (hit_result) begin
         dat_o = result_q;
      end
   end

   // Datapath next values: edge count, gate down-timer, result, status flags
   always_comb begin
      count_d  = count_q;
      timer_d  = timer_q;
      result_d = result_q;
      done_d   = done_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               done_d = 1'b0;
               ovf_d  = 1'b0;
            end
         end
         ST_ARM: begin
            count_d = 32'd0;
            timer_d = GATE_CYCLES - 32'd1;
         end
         ST_GATE: begin
            if (rise) begin
               if (count_q != CNT_MAX) begin
                  count_d = count_q + 32'd1;
               end
               if (count_q >= CNT_MAX - 32'd1) begin
                  ovf_d = 1'b1;
               end
            end
            if (timer_q != 32'd0) begin
               timer_d = timer_q - 32'd1;
            end
         end
         ST_LATCH: begin
            result_d = count_q;
            done_d   = 1'b1;
         end
         default: ;
      endcase
      if (clr_req) begin
         count_d  = 32'd0;
         done_d   = 1'b0;
         ovf_d    = 1'b0;
         result_d = result_q;
      end
   end

   // Datapath and synchroniser registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q   <= '0;
         sig_q    <= 1'b0;
         count_q  <= 32'd0;
         timer_q  <= 32'd0;
         result_q <= 32'd0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         sig_q    <= sig_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         result_q <= result_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_freq_counter_wb.sv
// Self-checking bench for freq_counter_wb with a short gate window.
module tb_freq_counter_wb;

   localparam logic [31:0] GATE   = 32'd100;
   localparam int          SYNC   = 2;
   localparam logic [31:0] A_CTRL = 32'h8;
   localparam logic [31:0] A_RES  = 32'h9;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] addr_i, dat_i, dat_o;
   logic        we_i;
   logic [3:0]  sel_i;
   logic        stb_i, cyc_i, ack_o;
   logic        sig_i = 1'b0;
   logic        busy_o;

   int checks   = 0;
   int failures = 0;

   freq_counter_wb #(
      .GATE_CYCLES (GATE),
      .SYNC_STAGES (SYNC),
      .CTRL_ADDR   (A_CTRL),
      .RESULT_ADDR (A_RES)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .addr_i (addr_i),
      .dat_i  (dat_i),
      .dat_o  (dat_o),
      .we_i   (we_i),
      .sel_i  (sel_i),
      .stb_i  (stb_i),
      .cyc_i  (cyc_i),
      .ack_o  (ack_o),
      .sig_i  (sig_i),
      .busy_o (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Record sig_i as seen at every rising edge; edge_n is the index of the next edge
   int edge_n = 0;
   bit hist [0:65535];
   always @(posedge clk_i) begin
      hist[edge_n[15:0]] = sig_i;
      edge_n = edge_n + 1;
   end

   // sig_i generator: 0 = held low, 1 = periodic, 2 = random toggling
   int sig_mode = 0;
   int sig_per  = 10;
   int sig_ph   = 0;
   int sig_pct  = 50;
   always @(negedge clk_i) begin
      case (sig_mode)
         1: begin
            sig_i  = (sig_ph < sig_per / 2);
            sig_ph = (sig_ph + 1 >= sig_per) ? 0 : sig_ph + 1;
         end
         2: if ($urandom_range(99) < sig_pct) sig_i = ~sig_i;
         default: sig_i = 1'b0;
      endcase
   end

   // Reference: the gate observes GATE consecutive samples of sig_i, offset by
   // the synchroniser depth from the START write edge e0; count 0->1 steps.
   function automatic int model_count(input int e0);
      int n = 0;
      for (int m = e0 + 2 - SYNC; m <= e0 + int'(GATE) + 1 - SYNC; m++) begin
         if (hist[m & 16'hFFFF] && !hist[(m - 1) & 16'hFFFF]) n++;
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic k);
      @(negedge clk_i);
      addr_i = a; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
      #1;
      d = dat_o;
      k = ack_o;
      stb_i = 1'b0; cyc_i = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int e);
      @(negedge clk_i);
      addr_i = a; dat_i = d; sel_i = s; we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
      @(posedge clk_i);
      #1;
      e = edge_n - 1;
      stb_i = 1'b0; we_i = 1'b0; cyc_i = 1'b0;
   endtask

   // Poll CTRL each cycle after a START at edge e0; optionally retry START at offset inject_j
   task automatic poll_done(input int e0, input int inject_j, output int first_j, output int busy_n);
      logic [31:0] d;
      logic        k;
      int          e_dummy;
      first_j = -1;
      busy_n  = 0;
      for (int it = 0; it < 400 && first_j < 0; it++) begin
         bus_read(A_CTRL, d, k);
         if (busy_o) busy_n++;
         if (d[6]) first_j = edge_n - 1 - e0;
         if (inject_j >= 0 && (edge_n - 1 - e0) == inject_j) begin
            bus_write(A_CTRL, 32'h80, 4'h1, e_dummy);
            chk("busy_after_ignored_start", {31'd0, busy_o}, 32'd1);
         end
      end
      if (first_j < 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: DONE not seen within 400 cycles");
      end
   endtask

   typedef struct packed {
      logic [31:0] addr;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdat;
      logic        exp_ack;
      logic        chk_dat;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t vecs [0:13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, res_prev;
      logic        k;
      int          e0, fj, bn, e_dummy;

      rst_i = 1'b1; addr_i = '0; dat_i = '0; we_i = 1'b0; sel_i = '0;
      stb_i = 1'b0; cyc_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      // Reset state
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      bus_read(A_CTRL, d, k);
      chk("rst_ctrl_dat", d, 32'd0);
      chk("rst_ctrl_ack", {31'd0, k}, 32'd1);
      bus_read(A_RES, d, k);
      chk("rst_res_dat", d, 32'd0);
      chk("rst_res_ack", {31'd0, k}, 32'd1);

      // Register access table: addr, stb, we, sel, wdat, exp_ack, chk_dat, exp_dat
      vecs[0]  = '{A_CTRL,       1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
      vecs[1]  = '{A_RES,        1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
      vecs[2]  = '{32'h7,        1'b1, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0};
      vecs[3]  = '{32'hA,        1'b1, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0};
      vecs[4]  = '{32'h1000_0008,1'b1, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0};
      vecs[5]  = '{A_CTRL,       1'b0, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0};
      vecs[6]  = '{A_RES,        1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      vecs[7]  = '{A_RES,        1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
      vecs[8]  = '{A_CTRL,       1'b1, 1'b1, 4'h2, 32'h80,       1'b1, 1'b0, 32'h0};
      vecs[9]  = '{A_CTRL,       1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
      vecs[10] = '{A_CTRL,       1'b1, 1'b1, 4'h1, 32'h81,       1'b1, 1'b0, 32'h0};
      vecs[11] = '{A_CTRL,       1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
      vecs[12] = '{32'h7,        1'b1, 1'b1, 4'h1, 32'h80,       1'b0, 1'b1, 32'h0};
      vecs[13] = '{A_CTRL,       1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
      for (int i = 0; i < 14; i++) begin
         @(negedge clk_i);
         addr_i = vecs[i].addr; stb_i = vecs[i].stb; cyc_i = vecs[i].stb;
         we_i = vecs[i].we; sel_i = vecs[i].sel; dat_i = vecs[i].wdat;
         #1;
         chk($sformatf("vec%0d_ack", i), {31'd0, ack_o}, {31'd0, vecs[i].exp_ack});
         if (vecs[i].chk_dat) chk($sformatf("vec%0d_dat", i), dat_o, vecs[i].exp_dat);
         @(posedge clk_i);
         #1;
         stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
      end
      chk("table_busy", {31'd0, busy_o}, 32'd0);

      // Period-10 signal: DONE latency, busy width and count
      sig_mode = 1; sig_per = 10;
      repeat (5) @(negedge clk_i);
      bus_write(A_CTRL, 32'h80, 4'h1, e0);
      poll_done(e0, -1, fj, bn);
      chk("p10_done_latency", fj, 32'd102);
      chk("p10_busy_cycles", bn, 32'd101);
      bus_read(A_RES, d, k);
      chk("p10_result", d, 32'd10);
      chk("p10_result_model", d, model_count(e0));
      bus_read(A_CTRL, d, k);
      chk("p10_ctrl", d, 32'h40);

      // Held-low signal, then CLR keeps RESULT
      sig_mode = 0;
      repeat (3) @(negedge clk_i);
      bus_write(A_CTRL, 32'h80, 4'h1, e0);
      poll_done(e0, -1, fj, bn);
      bus_read(A_RES, d, k);
      chk("low_result", d, 32'd0);
      bus_read(A_CTRL, d, k);
      chk("low_ctrl_done", d, 32'h40);
      bus_write(A_CTRL, 32'h01, 4'h1, e_dummy);
      bus_read(A_CTRL, d, k);
      chk("clr_ctrl", d, 32'h0);
      bus_read(A_RES, d, k);
      chk("clr_result_kept", d, 32'd0);

      // START retried mid-gate is ignored; CLR+START in IDLE stays idle
      sig_mode = 1; sig_per = 8;
      repeat (4) @(negedge clk_i);
      bus_write(A_CTRL, 32'h80, 4'h1, e0);
      poll_done(e0, 50, fj, bn);
      chk("restart_done_latency", fj, 32'd102);
      bus_read(A_RES, d, k);
      chk("p8_result_model", d, model_count(e0));
      res_prev = d;
      bus_write(A_CTRL, 32'h81, 4'h1, e_dummy);
      repeat (3) @(negedge clk_i);
      chk("clrstart_busy", {31'd0, busy_o}, 32'd0);
      bus_read(A_CTRL, d, k);
      chk("clrstart_ctrl", d, 32'h0);
      bus_read(A_RES, d, k);
      chk("clrstart_result_kept", d, res_prev);

      // CLR mid-gate aborts without touching RESULT
      sig_mode = 2; sig_pct = 30;
      bus_write(A_CTRL, 32'h80, 4'h1, e0);
      for (int it = 0; it < 60 && (edge_n - 1 - e0) < 40; it++) bus_read(A_RES, d, k);
      chk("midgate_result_old", d, res_prev);
      chk("midgate_busy", {31'd0, busy_o}, 32'd1);
      bus_write(A_CTRL, 32'h01, 4'h1, e_dummy);
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      bus_read(A_CTRL, d, k);
      chk("abort_ctrl", d, 32'h0);
      repeat (120) @(negedge clk_i);
      bus_read(A_CTRL, d, k);
      chk("abort_no_done", d, 32'h0);
      bus_read(A_RES, d, k);
      chk("abort_result_kept", d, res_prev);

      // Reset pulse mid-gate
      bus_write(A_CTRL, 32'h80, 4'h1, e0);
      repeat (30) @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
      bus_read(A_RES, d, k);
      chk("rstmid_result", d, 32'd0);
      bus_read(A_CTRL, d, k);
      chk("rstmid_ctrl", d, 32'h0);
      rst_i = 1'b0;
      repeat (120) @(negedge clk_i);
      bus_read(A_CTRL, d, k);
      chk("rstmid_no_done", d, 32'h0);
      bus_read(A_RES, d, k);
      chk("rstmid_no_partial", d, 32'd0);

      // Randomised measurements against the reference
      for (int r = 0; r < 8; r++) begin
         if (r % 2 == 1) begin
            sig_mode = 1;
            sig_per  = $urandom_range(20, 2);
         end else begin
            sig_mode = 2;
            sig_pct  = $urandom_range(95, 5);
         end
         repeat ($urandom_range(7, 1)) @(negedge clk_i);
         bus_write(A_CTRL, 32'h80 | ($urandom & 32'hFFFF_FF00), 4'h1 | 4'($urandom_range(15)), e0);
         poll_done(e0, -1, fj, bn);
         chk($sformatf("rnd%0d_latency", r), fj, 32'd102);
         bus_read(A_RES, d, k);
         chk($sformatf("rnd%0d_result", r), d, model_count(e0));
         bus_read(A_CTRL, d, k);
         chk($sformatf("rnd%0d_ctrl", r), d, 32'h40);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
